// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage with PC, IF/ID register, one-entry skid buffer, redirect and halt
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] npc,
  output logic        instr_valid
);
  localparam logic [0:0] FETCH  = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  logic [0:0]  state;
  logic [31:0] pc, instr_q, buf_instr, buf_pc, buf_npc;
  logic        buf_valid, may_load, accept;
  // read enable drops while the skid buffer holds a word or once halted
  always_comb begin
    iREN     = (state == FETCH) && !buf_valid && nRST;
    accept   = ihit && iREN && !redirect;
    may_load = !instr_valid || !stall;
    iaddr    = pc;
    instr    = instr_valid ? instr_q : 32'h0;
  end
  // prioritised update: redirect, halt, buffer drain, accept, skid capture, bubble, hold
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      instr_valid <= 1'b0;
      instr_q     <= 32'h0;
      pc_out      <= 32'h0;
      npc         <= 32'h0;
      buf_valid   <= 1'b0;
      buf_instr   <= 32'h0;
      buf_pc      <= 32'h0;
      buf_npc     <= 32'h0;
    end else if (state == FETCH) begin
      if (redirect) begin
        pc          <= redirect_pc;
        instr_valid <= 1'b0;
        buf_valid   <= 1'b0;
      end else if (halt && instr_valid && !stall) begin
        state       <= HALTED;
        instr_valid <= 1'b0;
        buf_valid   <= 1'b0;
      end else if (buf_valid && may_load) begin
        instr_q     <= buf_instr;
        pc_out      <= buf_pc;
        npc         <= buf_npc;
        instr_valid <= 1'b1;
        buf_valid   <= 1'b0;
      end else if (accept && may_load) begin
        instr_q     <= iload;
        pc_out      <= pc;
        npc         <= pc + 32'd4;
        instr_valid <= 1'b1;
        pc          <= pc + 32'd4;
      end else if (accept) begin
        buf_instr   <= iload;
        buf_pc      <= pc;
        buf_npc     <= pc + 32'd4;
        buf_valid   <= 1'b1;
        pc          <= pc + 32'd4;
      end else if (may_load) begin
        instr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, skid, redirect, halt and PC wrap
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        nrst, ihit, stall, redirect, halt, ovr_en;
  logic [31:0] redirect_pc, ovr;
  logic        iren, valid, iren_w, valid_w;
  logic [31:0] iaddr, iload, instr, pc_out, npc;
  logic [31:0] iaddr_w, iload_w, instr_w, pc_out_w, npc_w;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  assign iload   = ovr_en ? ovr : word(iaddr);
  assign iload_w = word(iaddr_w);
  fetch_unit u_dut (
    .CLK(clk), .nRST(nrst), .iREN(iren), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr(instr), .pc_out(pc_out), .npc(npc), .instr_valid(valid)
  );
  fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
    .CLK(clk), .nRST(nrst), .iREN(iren_w), .iaddr(iaddr_w), .ihit(ihit), .iload(iload_w),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr(instr_w), .pc_out(pc_out_w), .npc(npc_w), .instr_valid(valid_w)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_if(input string tag, input logic [31:0] a);
    chk({tag, " valid"}, {31'h0, valid}, 32'h1);
    chk({tag, " instr"}, instr, word(a));
    chk({tag, " pc_out"}, pc_out, a);
    chk({tag, " npc"}, npc, a + 32'd4);
  endtask
  initial begin
    nrst = 1'b0; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    redirect_pc = 32'h0; ovr_en = 1'b0; ovr = 32'h0;
    step();
    chk("rst valid", {31'h0, valid}, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst npc", npc, 32'h0);
    chk("rst iaddr", iaddr, 32'h0);
    chk("rst iren", {31'h0, iren}, 32'h0);
    chk("rst wrap iaddr", iaddr_w, 32'hFFFF_FFFC);
    nrst = 1'b1;
    #1;
    chk("iren after rst", {31'h0, iren}, 32'h1);
    ihit = 1'b1;
    step();
    chk_if("fetch0", 32'h0);
    chk("fetch0 iaddr", iaddr, 32'h4);
    chk("wrap pc_out", pc_out_w, 32'hFFFF_FFFC);
    chk("wrap npc", npc_w, 32'h0);
    chk("wrap iaddr", iaddr_w, 32'h0);
    chk("wrap instr", instr_w, word(32'hFFFF_FFFC));
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_if("stream", 32'(4 * k));
      chk("stream iaddr", iaddr, 32'(4 * k + 4));
    end
    stall = 1'b1;
    step();
    chk_if("stall1", 32'd12);
    chk("stall1 iren", {31'h0, iren}, 32'h0);
    chk("stall1 iaddr", iaddr, 32'd20);
    step();
    chk_if("stall2", 32'd12);
    chk("stall2 iren", {31'h0, iren}, 32'h0);
    stall = 1'b0;
    step();
    chk_if("drain", 32'd16);
    chk("drain iren", {31'h0, iren}, 32'h1);
    chk("drain iaddr", iaddr, 32'd20);
    step();
    chk_if("resume", 32'd20);
    stall = 1'b1;
    step();
    chk("skid2 iren", {31'h0, iren}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    chk("redir valid", {31'h0, valid}, 32'h0);
    chk("redir instr", instr, 32'h0);
    chk("redir iaddr", iaddr, 32'h100);
    chk("redir iren", {31'h0, iren}, 32'h1);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk_if("target", 32'h100);
    redirect = 1'b1; redirect_pc = 32'h200; ovr_en = 1'b1; ovr = 32'hDEAD_BEEF;
    step();
    chk("redir2 valid", {31'h0, valid}, 32'h0);
    chk("redir2 iaddr", iaddr, 32'h200);
    redirect = 1'b0; ovr_en = 1'b0;
    step();
    chk_if("target2", 32'h200);
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    step();
    chk("rh iaddr", iaddr, 32'h300);
    chk("rh iren", {31'h0, iren}, 32'h1);
    chk("rh valid", {31'h0, valid}, 32'h0);
    halt = 1'b0; redirect = 1'b0;
    step();
    chk_if("rh fetch", 32'h300);
    halt = 1'b1;
    step();
    chk("halt valid", {31'h0, valid}, 32'h0);
    chk("halt iren", {31'h0, iren}, 32'h0);
    chk("halt instr", instr, 32'h0);
    chk("halt iaddr", iaddr, 32'h304);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
    step();
    chk("halted redir iaddr", iaddr, 32'h304);
    chk("halted iren", {31'h0, iren}, 32'h0);
    redirect = 1'b0;
    step();
    chk("halted valid", {31'h0, valid}, 32'h0);
    chk("halted iren2", {31'h0, iren}, 32'h0);
    nrst = 1'b0;
    step();
    chk("rst2 iaddr", iaddr, 32'h0);
    chk("rst2 iren", {31'h0, iren}, 32'h0);
    nrst = 1'b1;
    step();
    chk_if("post halt", 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
